// File: rtl/bias_pipe_unit_if.sv
// Bus bundle for bias_pipe_unit: schedule/decoder control, wagu request,
// bias-buffer read side, NPE result input and relu-facing result output.
// The master modport is the environment driving the unit; slave is the unit.
interface bias_pipe_unit_if #(
  parameter int LANES      = 32,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                          calculate_enble;
  logic [4:0]                    part_num;
  logic [7:0]                    out_piece;
  logic [ADDR_WIDTH-1:0]         addr_start_b;
  logic                          pe_out_en;
  logic [LANES*DATA_WIDTH-1:0]   bias_data;
  logic                          bias_data_valid;
  logic [LANES*DATA_WIDTH-1:0]   npe_data_out;
  logic                          npe_data_valid;
  logic [ADDR_WIDTH-1:0]         o_b_addr;
  logic                          o_rd_en;
  logic [LANES*DATA_WIDTH-1:0]   o_bias_result;
  logic                          o_bias_result_valid;
  logic                          o_done;
  logic [1:0]                    o_err;

  modport master (
    output calculate_enble, part_num, out_piece, addr_start_b, pe_out_en,
           bias_data, bias_data_valid, npe_data_out, npe_data_valid,
    input  o_b_addr, o_rd_en, o_bias_result, o_bias_result_valid, o_done, o_err
  );

  modport slave (
    input  calculate_enble, part_num, out_piece, addr_start_b, pe_out_en,
           bias_data, bias_data_valid, npe_data_out, npe_data_valid,
    output o_b_addr, o_rd_en, o_bias_result, o_bias_result_valid, o_done, o_err
  );
endinterface

// File: rtl/bias_pipe_unit.sv
// bias_pipe_unit: bias-buffer address generation from part/piece loop
// counters, a small bias FIFO absorbing bias-buffer read latency, and a
// registered lane-wise bias add towards relu, with done pulse and sticky
// underflow/overflow flags.
// Build option: define BIAS_SATURATE_EN to clamp each lane sum instead of
// letting it wrap.
module bias_pipe_unit #(
  parameter int LANES      = 32,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  bias_pipe_unit_if.slave  bus
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WORD_W = LANES * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

`ifdef BIAS_SATURATE_EN
  function automatic logic signed [DATA_WIDTH-1:0] sat_lane(
    input logic signed [DATA_WIDTH:0] s
  );
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
      return s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      return s[DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] lane_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] s;
    s = (DATA_WIDTH+1)'(a) + (DATA_WIDTH+1)'(b);
    return sat_lane(s);
  endfunction
`else
  function automatic logic signed [DATA_WIDTH-1:0] lane_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return a + b;
  endfunction
`endif

  state_t                r_state, w_state_nxt;
  logic [4:0]            r_p, r_part_cnt;
  logic [7:0]            r_q, r_piece_cnt;
  logic [ADDR_WIDTH-1:0] r_base, r_b_addr;
  logic                  r_rd_en;
  logic [1:0]            r_err;
  logic                  w_done;

  logic [WORD_W-1:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]        r_count;

  logic signed [WORD_W-1:0] r_bias_result_p1;
  logic                     r_vld_p1;

  logic w_start, w_req, w_last_piece, w_last_part;
  logic w_empty, w_full, w_bypass, w_push, w_pop, w_ovf, w_unf;
  logic [WORD_W-1:0] w_head, w_sum;

  assign w_start      = (r_state == S_IDLE) && bus.calculate_enble;
  assign w_req        = (r_state == S_RUN) && bus.pe_out_en;
  assign w_last_piece = (r_piece_cnt == r_q - 8'd1);
  assign w_last_part  = (r_part_cnt == r_p - 5'd1);

  // A push into an empty FIFO that coincides with a pop is forwarded
  // straight to the adder and never stored.
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_bypass = bus.npe_data_valid && bus.bias_data_valid && w_empty;
  assign w_pop    = bus.npe_data_valid && !w_empty;
  assign w_push   = bus.bias_data_valid && !w_bypass && (!w_full || w_pop);
  assign w_ovf    = bus.bias_data_valid && w_full && !w_pop;
  assign w_unf    = bus.npe_data_valid && w_empty && !bus.bias_data_valid;

  // Select the bias word for the add: stored head, bypassed word, or zero on underflow.
  always_comb begin
    w_head = '0;
    if (!w_empty)
      w_head = r_mem[r_rd_ptr];
    else if (bus.bias_data_valid)
      w_head = bus.bias_data;
  end

  // Lane-wise bias add.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++)
      w_sum[i*DATA_WIDTH +: DATA_WIDTH] =
        lane_add(bus.npe_data_out[i*DATA_WIDTH +: DATA_WIDTH],
                 w_head[i*DATA_WIDTH +: DATA_WIDTH]);
  end

  // Next-state logic; done fires in the cycle DRAIN hands back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.calculate_enble) w_state_nxt = S_RUN;
      S_RUN:   if (w_req && w_last_piece && w_last_part) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_empty && !r_vld_p1) begin
                 w_state_nxt = S_IDLE;
                 w_done      = 1'b1;
               end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Latch layer shape at start and step the piece/part loop on each request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p         <= '0;
      r_q         <= '0;
      r_base      <= '0;
      r_piece_cnt <= '0;
      r_part_cnt  <= '0;
    end else if (w_start) begin
      r_p         <= (bus.part_num == 5'd0) ? 5'd1 : bus.part_num;
      r_q         <= (bus.out_piece == 8'd0) ? 8'd1 : bus.out_piece;
      r_base      <= bus.addr_start_b;
      r_piece_cnt <= '0;
      r_part_cnt  <= '0;
    end else if (w_req) begin
      if (w_last_piece) begin
        r_piece_cnt <= '0;
        r_part_cnt  <= r_part_cnt + 5'd1;
      end else begin
        r_piece_cnt <= r_piece_cnt + 8'd1;
      end
    end
  end

  // Issue one bias-buffer read per request, one cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_en  <= 1'b0;
      r_b_addr <= '0;
    end else begin
      r_rd_en <= w_req;
      if (w_req) r_b_addr <= r_base + ADDR_WIDTH'(r_piece_cnt);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.bias_data;
  end

  // Sticky error flags, cleared by a new layer start.
  always_ff @(posedge clk) begin
    if (rst)          r_err <= 2'b00;
    else if (w_start) r_err <= 2'b00;
    else              r_err <= r_err | {w_ovf, w_unf};
  end

  // ---- stage p0 -> p1: registered biased result ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1         <= 1'b0;
      r_bias_result_p1 <= '0;
    end else begin
      r_vld_p1 <= bus.npe_data_valid;
      if (bus.npe_data_valid) r_bias_result_p1 <= w_sum;
    end
  end

  assign bus.o_b_addr            = r_b_addr;
  assign bus.o_rd_en             = r_rd_en;
  assign bus.o_bias_result       = r_bias_result_p1;
  assign bus.o_bias_result_valid = r_vld_p1;
  assign bus.o_done              = w_done;
  assign bus.o_err               = r_err;

endmodule

// File: tb/tb_bias_pipe_unit.sv
// Directed bench for bias_pipe_unit: address sequencing, bypass add,
// wrap/saturate arithmetic, FIFO error flags, degenerate shapes and reset abort.
module tb_bias_pipe_unit;
  localparam int LANES = 32;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int FD    = 4;
  localparam int WW    = LANES * DW;

`ifdef BIAS_SATURATE_EN
  localparam logic [15:0] E_POS = 16'h7FFF;
  localparam logic [15:0] E_NEG = 16'h8000;
`else
  localparam logic [15:0] E_POS = 16'h8010;
  localparam logic [15:0] E_NEG = 16'h7FFF;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bias_pipe_unit_if #(.LANES(LANES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  bias_pipe_unit #(.LANES(LANES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [WW-1:0] rep(input logic [15:0] v);
    logic [WW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [WW-1:0] alt(input logic [15:0] ev, input logic [15:0] od);
    logic [WW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = (i % 2 == 0) ? ev : od;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.calculate_enble = 1'b0;
    bus.part_num        = '0;
    bus.out_piece       = '0;
    bus.addr_start_b    = '0;
    bus.pe_out_en       = 1'b0;
    bus.bias_data       = '0;
    bus.bias_data_valid = 1'b0;
    bus.npe_data_out    = '0;
    bus.npe_data_valid  = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] p, input logic [7:0] q, input logic [7:0] base);
    bus.calculate_enble = 1'b1;
    bus.part_num        = p;
    bus.out_piece       = q;
    bus.addr_start_b    = base;
    tick();
    bus.calculate_enble = 1'b0;
  endtask

  task automatic pulse();
    bus.pe_out_en = 1'b1;
    tick();
    bus.pe_out_en = 1'b0;
  endtask

  task automatic bypass_add(input logic [WW-1:0] npe, input logic [WW-1:0] bias);
    bus.npe_data_out    = npe;
    bus.bias_data       = bias;
    bus.npe_data_valid  = 1'b1;
    bus.bias_data_valid = 1'b1;
    tick();
    bus.npe_data_valid  = 1'b0;
    bus.bias_data_valid = 1'b0;
  endtask

  logic [7:0] exp_addr [6];

  initial begin
    exp_addr = '{8'h10, 8'h11, 8'h12, 8'h10, 8'h11, 8'h12};
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_addr",  bus.o_b_addr, 0);
    chk("rst_rd_en", bus.o_rd_en, 0);
    chk("rst_res",   bus.o_bias_result, 0);
    chk("rst_vld",   bus.o_bias_result_valid, 0);
    chk("rst_done",  bus.o_done, 0);
    chk("rst_err",   bus.o_err, 0);

    // Address sequence: 2 parts x 3 pieces from 0x10
    do_start(5'd2, 8'd3, 8'h10);
    for (int k = 0; k < 6; k++) begin
      bus.pe_out_en       = 1'b1;
      bus.bias_data_valid = 1'b1;
      bus.bias_data       = rep(16'(k + 1));
      tick();
      bus.pe_out_en       = 1'b0;
      bus.bias_data_valid = 1'b0;
      chk($sformatf("seq_rd_en_%0d", k), bus.o_rd_en, 1);
      chk($sformatf("seq_addr_%0d", k), bus.o_b_addr, exp_addr[k]);
      chk($sformatf("seq_done_a_%0d", k), bus.o_done, 0);
      bus.npe_data_valid = 1'b1;
      bus.npe_data_out   = rep(16'h0100);
      bus.pe_out_en      = (k == 5);
      tick();
      bus.npe_data_valid = 1'b0;
      bus.pe_out_en      = 1'b0;
      chk($sformatf("seq_vld_%0d", k), bus.o_bias_result_valid, 1);
      chk($sformatf("seq_res_%0d", k), bus.o_bias_result, rep(16'h0100 + 16'(k + 1)));
      chk($sformatf("seq_rd_low_%0d", k), bus.o_rd_en, 0);
      chk($sformatf("seq_done_b_%0d", k), bus.o_done, 0);
    end
    tick();
    chk("seq_done_pulse", bus.o_done, 1);
    chk("seq_vld_low", bus.o_bias_result_valid, 0);
    tick();
    chk("seq_done_end", bus.o_done, 0);
    pulse();
    chk("idle_req_ignored", bus.o_rd_en, 0);

    // Bypass add into empty FIFO
    bypass_add(rep(16'h0003), rep(16'h0005));
    chk("byp_vld", bus.o_bias_result_valid, 1);
    chk("byp_res", bus.o_bias_result, rep(16'h0008));
    chk("byp_err", bus.o_err, 0);
    tick();
    chk("byp_vld_low", bus.o_bias_result_valid, 0);

    // Overflow/underflow arithmetic
    bypass_add(rep(16'h7FF0), rep(16'h0020));
    chk("sat_pos", bus.o_bias_result, rep(E_POS));
    bypass_add(rep(16'h8000), rep(16'hFFFF));
    chk("sat_neg", bus.o_bias_result, rep(E_NEG));
    bypass_add(alt(16'h7FF0, 16'h8000), alt(16'h0020, 16'hFFFF));
    chk("sat_mixed", bus.o_bias_result, alt(E_POS, E_NEG));
    bypass_add(alt(16'h1234, 16'hFFFE), alt(16'h0001, 16'h0003));
    chk("add_mixed", bus.o_bias_result, alt(16'h1235, 16'h0001));

    // FIFO overflow then in-order pops then underflow
    for (int k = 0; k < 5; k++) begin
      bus.bias_data_valid = 1'b1;
      bus.bias_data       = rep(16'h00A1 + 16'(k));
      tick();
      if (k == 3) chk("ovf_err_before", bus.o_err, 2'b00);
    end
    bus.bias_data_valid = 1'b0;
    chk("ovf_err", bus.o_err, 2'b10);
    for (int k = 0; k < 4; k++) begin
      bus.npe_data_valid = 1'b1;
      bus.npe_data_out   = '0;
      tick();
      chk($sformatf("fifo_pop_%0d", k), bus.o_bias_result, rep(16'h00A1 + 16'(k)));
    end
    bus.npe_data_out = rep(16'h0007);
    tick();
    bus.npe_data_valid = 1'b0;
    chk("unf_res", bus.o_bias_result, rep(16'h0007));
    chk("unf_vld", bus.o_bias_result_valid, 1);
    chk("unf_err", bus.o_err, 2'b11);

    // Zero shape: one request at base, start clears errors
    do_start(5'd0, 8'd0, 8'h40);
    chk("zero_err_clr", bus.o_err, 0);
    pulse();
    chk("zero_rd_en", bus.o_rd_en, 1);
    chk("zero_addr", bus.o_b_addr, 8'h40);
    chk("zero_done", bus.o_done, 1);
    tick();
    chk("zero_done_end", bus.o_done, 0);

    // Address wrap, start ignored while running
    do_start(5'd1, 8'd2, 8'hFF);
    pulse();
    chk("wrap_addr0", bus.o_b_addr, 8'hFF);
    chk("wrap_done0", bus.o_done, 0);
    do_start(5'd3, 8'd5, 8'h33);
    pulse();
    chk("wrap_addr1", bus.o_b_addr, 8'h00);
    chk("wrap_rd_en1", bus.o_rd_en, 1);
    chk("wrap_done1", bus.o_done, 1);
    tick();

    // Reset mid-run aborts the layer
    do_start(5'd2, 8'd3, 8'h20);
    pulse();
    chk("abort_addr0", bus.o_b_addr, 8'h20);
    bus.npe_data_valid = 1'b1;
    bus.npe_data_out   = rep(16'h0055);
    pulse();
    bus.npe_data_valid = 1'b0;
    chk("abort_addr1", bus.o_b_addr, 8'h21);
    chk("abort_err_pre", bus.o_err, 2'b01);
    chk("abort_res_pre", bus.o_bias_result, rep(16'h0055));
    rst                 = 1'b1;
    bus.pe_out_en       = 1'b1;
    bus.npe_data_valid  = 1'b1;
    bus.bias_data_valid = 1'b1;
    bus.bias_data       = rep(16'h0009);
    tick();
    clear_inputs();
    chk("abort_addr", bus.o_b_addr, 0);
    chk("abort_rd_en", bus.o_rd_en, 0);
    chk("abort_res", bus.o_bias_result, 0);
    chk("abort_vld", bus.o_bias_result_valid, 0);
    chk("abort_done", bus.o_done, 0);
    chk("abort_err", bus.o_err, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("abort_no_done_%0d", k), bus.o_done, 0);
    end
    do_start(5'd2, 8'd3, 8'h20);
    pulse();
    chk("restart_addr", bus.o_b_addr, 8'h20);
    chk("restart_rd_en", bus.o_rd_en, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bias_pipe_unit.md
Name: bias_pipe_unit

Overview:
- Generalised successor of the NPE bias stage: parametrised lane count and lane width.
- Bias-buffer address generator driven by part and piece loop counters.
- Small bias FIFO decouples bias-buffer read latency from NPE result arrival.
- Registered lane-wise bias add feeding relu, plus completion and error flags.
- Sits between NPE output, bias buffer and relu; controlled by schedule and decoder.

Parameters:
- LANES, 32, number of parallel output lanes.
- DATA_WIDTH, 16, signed two's-complement width per lane.
- ADDR_WIDTH, 8, bias buffer address width.
- FIFO_DEPTH, 4, bias FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- calculate_enble  in  1  start pulse from schedule; sampled only in IDLE.
- part_num  in  5  number of parts; 0 is treated as 1; latched at start.
- out_piece  in  8  pieces per part; 0 is treated as 1; latched at start.
- addr_start_b  in  ADDR_WIDTH  first bias address; latched at start.
- pe_out_en  in  1  from wagu; one pulse per output piece requests one bias word.
- bias_data  in  LANES*DATA_WIDTH  bias word from bias buffer.
- bias_data_valid  in  1  bias_data qualifier.
- npe_data_out  in  LANES*DATA_WIDTH  NPE result word.
- npe_data_valid  in  1  npe_data_out qualifier.
- o_b_addr  out  ADDR_WIDTH  bias buffer read address.
- o_rd_en  out  1  bias buffer read strobe.
- o_bias_result  out  LANES*DATA_WIDTH  biased result to relu.
- o_bias_result_valid  out  1  result qualifier.
- o_done  out  1  one-cycle pulse when the layer completes.
- o_err  out  2  sticky flags: bit0 FIFO underflow, bit1 FIFO overflow.

Behaviour:
- Reset: all outputs 0, FIFO empty, counters 0, state IDLE, o_err cleared.
- Reset asserted mid-operation aborts the layer immediately; no o_done is generated.
- State machine has three states: IDLE, RUN and DRAIN.
- IDLE -> RUN on calculate_enble. Latch P = max(part_num,1), Q = max(out_piece,1) and base = addr_start_b. Clear piece_cnt, part_cnt and o_err.
- RUN, on each pe_out_en:
  - Next cycle: o_rd_en=1 for one cycle, o_b_addr = base + piece_cnt, modulo 2^ADDR_WIDTH.
  - Then piece_cnt increments. At Q-1, piece_cnt wraps to 0 and part_cnt increments.
  - The bias address sequence therefore repeats for every part.
- RUN -> DRAIN on the request that finishes the last piece of the last part (part_cnt = P-1, piece_cnt = Q-1).
- pe_out_en in IDLE or DRAIN is ignored.
- calculate_enble outside IDLE is ignored.
- bias_data_valid pushes bias_data into the FIFO.
  - Push while full: word dropped, o_err[1] set.
- npe_data_valid pops the FIFO head.
  - The head is usable when the FIFO is non-empty, or when a same-cycle push goes into an empty FIFO (bypass).
  - Next cycle: o_bias_result_valid=1 and o_bias_result lane i = npe lane i + bias lane i. Latency is exactly 1 cycle.
  - Pop while empty with no bypass: bias taken as 0, o_err[0] set, result still emitted.
  - Simultaneous push and pop on a non-empty FIFO: the count is unchanged and the pop returns the old head.
- Add arithmetic: wrapping signed add, result truncated to DATA_WIDTH; or saturating per the optional feature.
- DRAIN -> IDLE when the FIFO is empty and no result is pending. o_done pulses in the cycle of that transition.
- o_err holds until the next start or reset.

Optional Feature:
- Macro: BIAS_SATURATE_EN.
- Defined: each lane sum is computed at DATA_WIDTH+1 bits and clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: each lane sum wraps modulo 2^DATA_WIDTH.
- Latency is 1 cycle in both builds.

Test Plan:
- Sequence: start with part_num=2, out_piece=3, addr_start_b=0x10, then 6 pe_out_en pulses -> o_b_addr = 10,11,12,10,11,12 with one o_rd_en each. Enters DRAIN after pulse 6; o_done pulses once, after the 6th result.
- Add: bias lane = 0x0005, npe lane = 0x0003, both valid in the same cycle into an empty FIFO -> bypass; o_bias_result lane = 0x0008 with valid exactly 1 cycle later.
- Saturation: npe lane = 0x7FF0, bias lane = 0x0020 -> 0x7FFF with BIAS_SATURATE_EN, 0x8010 without. npe 0x8000 plus bias 0xFFFF -> 0x8000 with the macro, 0x7FFF without.
- Errors: 5 bias pushes with FIFO_DEPTH=4 and no pops -> o_err=2'b10; the first 4 words pop in order. A further pop on an empty FIFO -> bias 0 and o_err=2'b11.
- Boundaries: part_num=0 and out_piece=0 -> one request at addr_start_b. addr_start_b=0xFF with out_piece=2 -> addresses FF,00.
- Reset: rst asserted in RUN after 2 pulses -> all outputs 0 next cycle and no o_done. A new start then begins again at addr_start_b.
